triage_ward_scheduler: RTL and testbench
========================================

# triage_ward_scheduler

Multi-bed triage controller. It time-multiplexes one triage evaluation across NBED beds and holds a per-bed 2-bit triage state register file. Beds are scanned round-robin at a programmable rate, and each bed's actuator code is published on a shared bus. Sticky CRITICAL beds are escalated to a nurse alarm with an acknowledge handshake. It sits between the ward sensor aggregation and the central actuator/alarm panel.

## Interface
- NBED, 4: number of beds, 2..16
- SCAN_DIV, 1000: clock cycles between successive bed services, ≥3
- BW, derived: clog2(NBED), bed index width
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- S_BUS  in  6*NBED  sensor vectors; bed i on [6i+5:6i], bit order S5..S0
- ACK  in  1  nurse acknowledge; rising edge only is significant
- BED_SEL  out  BW  bed whose result is on A
- A  out  6  actuator code A5..A0 of BED_SEL
- A_VALID  out  1  one-cycle pulse: A/BED_SEL updated
- ALARM  out  1  high while any bed is CRITICAL
- ALARM_BED  out  BW  lowest-index CRITICAL bed, 0 when ALARM low
- STATE_BUS  out  2*NBED  per-bed state; bed i on [2i+1:2i]

## Operation
- Per-bed states: IDLE=00, OBSERVATION=01, PRE_CRITICAL=10, CRITICAL=11.
- Classification of a sampled vector S:
  - N = all bits 0.
  - H = S0S1 + S2S3 + S0S2.
  - L1 = (S5+S4)·¬H.
- Transitions (PS → NS):
  - IDLE: H→PRE_CRITICAL, else L1→OBSERVATION, else IDLE.
  - OBSERVATION: H→PRE_CRITICAL, else N→IDLE, else hold.
  - PRE_CRITICAL: H or L1→CRITICAL, else N→IDLE, else hold.
  - CRITICAL: hold. Only an acknowledge clears it.
- Actuator codes: IDLE 000000, OBSERVATION 001100, PRE_CRITICAL 011010, CRITICAL 111111.
- Scan controller FSM, with a bed pointer ptr:
  - WAIT: the divider counts down from SCAN_DIV-1. At 0 it reloads → SAMPLE.
  - SAMPLE: latch S_BUS slice of bed ptr → UPDATE.
  - UPDATE: write NS into state[ptr]; register A=code(NS), BED_SEL=ptr, A_VALID=1; ptr ← (ptr+1) mod NBED, wrapping NBED-1→0 → WAIT.
- Acknowledge:
  - ACK is synchronised by the caller. A rising edge is detected internally (registered previous ACK).
  - An edge while ALARM=1 sets state[ALARM_BED] ← IDLE.
  - An edge while ALARM=0 is ignored.
  - Holding ACK high clears exactly one bed.
- Simultaneous ACK-edge clear and UPDATE on the same bed: acknowledge wins. The state is written IDLE and A reports 000000.
- Simultaneous ACK-edge clear and UPDATE on different beds: both writes take effect.
- ALARM and ALARM_BED are registered, computed from the state file with lowest-index priority.

## Timing
- Reset values: all states IDLE, ptr=0, divider=SCAN_DIV-1, FSM=WAIT, A=0, A_VALID=0, BED_SEL=0, ALARM=0, ALARM_BED=0, STATE_BUS=0, ACK history=0.
- RST mid-operation aborts any scan step immediately. No partial write survives.
- Tick at cycle t (divider=0) → SAMPLE at t+1 → state written and A/A_VALID/BED_SEL visible at t+2. A_VALID is high for exactly one cycle.
- Bed service period is SCAN_DIV cycles; a full ward scan takes NBED·SCAN_DIV cycles.
- Sensor values are captured only in SAMPLE. Changes at other times are unseen until that bed's next slot.
- STATE_BUS reflects the register file one cycle after any write.
- ALARM/ALARM_BED lag STATE_BUS by one cycle.
- ACK rising edge at cycle t: state cleared at t+1, ALARM/ALARM_BED updated at t+2.
- A and BED_SEL hold their values between A_VALID pulses.

## Structure
- Shared package triage_pkg holds:
  - state encodings IDLE/OBSERVATION/PRE_CRITICAL/CRITICAL;
  - the four actuator code constants;
  - scan FSM encodings WAIT/SAMPLE/UPDATE.
- One combinational sub-module, triage_eval: inputs S[5:0] and PS[1:0]; outputs NS[1:0] and A[5:0]. It is instantiated once and shared by all beds.
- Top level holds the divider, scan FSM, pointer, state register file, ACK edge detector and alarm priority encoder.

## Test plan
- Reset: assert RST for 3 cycles, with RST also asserted asynchronously mid-cycle → all outputs 0 immediately, STATE_BUS=0; first A_VALID comes SCAN_DIV+1 cycles after release, with BED_SEL=0.
- NBED=4, SCAN_DIV=4, bed1 S=010000 → on bed1's pulse, A=001100, BED_SEL=1, STATE_BUS[3:2]=01; S→000000 on the next scan → A=000000, state 00.
- Bed2 S=000011 for two scans:
  - first scan → A=011010;
  - second scan → A=111111, ALARM=1, ALARM_BED=2;
  - S→000000 afterwards → bed2 stays 11.
- Beds 1 and 3 CRITICAL:
  - ALARM_BED=1;
  - first ACK edge → bed1 IDLE, ALARM_BED=3 two cycles later;
  - ACK held high for 20 cycles → bed3 unchanged;
  - second ACK edge → ALARM=0.
- ACK edge in the SAMPLE cycle of alarmed bed0, with S=111111 → bed0 written IDLE, A=000000, ALARM falls.
- Wrap-around over 3 full scans with distinct per-bed stimulus → BED_SEL sequence 0,1,2,3,0…; A_VALID spacing exactly SCAN_DIV cycles.

Source files
------------

// File: rtl/triage_pkg.sv
// Shared encodings for the triage ward scheduler: bed states, actuator codes
// and scan controller states.
package triage_pkg;

  localparam logic [1:0] IDLE         = 2'b00;
  localparam logic [1:0] OBSERVATION  = 2'b01;
  localparam logic [1:0] PRE_CRITICAL = 2'b10;
  localparam logic [1:0] CRITICAL     = 2'b11;

  localparam logic [5:0] A_IDLE         = 6'b000000;
  localparam logic [5:0] A_OBSERVATION  = 6'b001100;
  localparam logic [5:0] A_PRE_CRITICAL = 6'b011010;
  localparam logic [5:0] A_CRITICAL     = 6'b111111;

  localparam logic [1:0] SCAN_WAIT   = 2'd0;
  localparam logic [1:0] SCAN_SAMPLE = 2'd1;
  localparam logic [1:0] SCAN_UPDATE = 2'd2;

  function automatic logic [5:0] act_code(input logic [1:0] st);
    case (st)
      OBSERVATION:  return A_OBSERVATION;
      PRE_CRITICAL: return A_PRE_CRITICAL;
      CRITICAL:     return A_CRITICAL;
      default:      return A_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/triage_eval.sv
// Combinational triage evaluation for one bed: classifies the sensor vector
// and produces the next state plus its actuator code.
import triage_pkg::*;

module triage_eval (
  input  logic [5:0] S,
  input  logic [1:0] PS,
  output logic [1:0] NS,
  output logic [5:0] A
);

  logic h, n, l1;

  assign h  = (S[0] & S[1]) | (S[2] & S[3]) | (S[0] & S[2]);
  assign n  = (S == 6'b000000);
  assign l1 = (S[5] | S[4]) & ~h;

  always_comb begin
    NS = PS;
    case (PS)
      IDLE:         NS = h ? PRE_CRITICAL : (l1 ? OBSERVATION : IDLE);
      OBSERVATION:  NS = h ? PRE_CRITICAL : (n ? IDLE : OBSERVATION);
      PRE_CRITICAL: NS = (h | l1) ? CRITICAL : (n ? IDLE : PRE_CRITICAL);
      default:      NS = CRITICAL;
    endcase
  end

  assign A = act_code(NS);

endmodule

// File: rtl/triage_ward_scheduler.sv
// Round-robin multi-bed triage controller: one shared evaluator, per-bed state
// file, nurse alarm with acknowledge-edge clearing.
import triage_pkg::*;

module triage_ward_scheduler #(
  parameter  int NBED     = 4,
  parameter  int SCAN_DIV = 1000,
  localparam int BW       = (NBED > 1) ? $clog2(NBED) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [6*NBED-1:0]    S_BUS,
  input  logic                 ACK,
  output logic [BW-1:0]        BED_SEL,
  output logic [5:0]           A,
  output logic                 A_VALID,
  output logic                 ALARM,
  output logic [BW-1:0]        ALARM_BED,
  output logic [2*NBED-1:0]    STATE_BUS
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0]     div_q;
  logic [1:0]        fsm_q;
  logic [BW-1:0]     ptr_q;
  logic [2*NBED-1:0] st_q;
  logic              ack_q;

  logic              tick;
  logic [5:0]        s_cur;
  logic [1:0]        ps_cur, ns_ev, ns_fin;
  logic [5:0]        a_ev, a_fin;
  logic              ack_clr, clr_hit;
  logic              alarm_nx;
  logic [BW-1:0]     alarm_bed_nx;

  // The divider free-runs so the bed service period is exactly SCAN_DIV.
  assign tick   = (div_q == '0);
  assign s_cur  = S_BUS[6*int'(ptr_q) +: 6];
  assign ps_cur = st_q[2*int'(ptr_q) +: 2];

  triage_eval u_eval (
    .S  (s_cur),
    .PS (ps_cur),
    .NS (ns_ev),
    .A  (a_ev)
  );

  // An acknowledge landing on the bed being serviced overrides the evaluation.
  assign ack_clr = ACK & ~ack_q & ALARM;
  assign clr_hit = ack_clr && (ALARM_BED == ptr_q);
  assign ns_fin  = clr_hit ? IDLE   : ns_ev;
  assign a_fin   = clr_hit ? A_IDLE : a_ev;

  always_comb begin
    alarm_nx     = 1'b0;
    alarm_bed_nx = '0;
    for (int i = NBED - 1; i >= 0; i--) begin
      if (st_q[2*i +: 2] == CRITICAL) begin
        alarm_nx     = 1'b1;
        alarm_bed_nx = BW'(i);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q     <= DW'(SCAN_DIV - 1);
      fsm_q     <= SCAN_WAIT;
      ptr_q     <= '0;
      st_q      <= '0;
      ack_q     <= 1'b0;
      A         <= A_IDLE;
      A_VALID   <= 1'b0;
      BED_SEL   <= '0;
      ALARM     <= 1'b0;
      ALARM_BED <= '0;
    end else begin
      ack_q     <= ACK;
      ALARM     <= alarm_nx;
      ALARM_BED <= alarm_bed_nx;
      div_q     <= tick ? DW'(SCAN_DIV - 1) : div_q - DW'(1);
      A_VALID   <= 1'b0;
      if (ack_clr)
        st_q[2*int'(ALARM_BED) +: 2] <= IDLE;
      case (fsm_q)
        SCAN_WAIT: begin
          if (tick)
            fsm_q <= SCAN_SAMPLE;
        end
        SCAN_SAMPLE: begin
          st_q[2*int'(ptr_q) +: 2] <= ns_fin;
          A       <= a_fin;
          BED_SEL <= ptr_q;
          A_VALID <= 1'b1;
          fsm_q   <= SCAN_UPDATE;
        end
        SCAN_UPDATE: begin
          ptr_q <= (ptr_q == BW'(NBED - 1)) ? '0 : ptr_q + BW'(1);
          fsm_q <= SCAN_WAIT;
        end
        default: fsm_q <= SCAN_WAIT;
      endcase
    end
  end

  assign STATE_BUS = st_q;

endmodule

// File: tb/tb_triage_ward_scheduler.sv
// Self-checking bench for triage_ward_scheduler: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_triage_ward_scheduler;

  localparam int NBED = 4;
  localparam int D    = 4;
  localparam int BW   = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              ACK = 1'b0;
  logic [6*NBED-1:0] S_BUS = '0;
  logic [BW-1:0]     BED_SEL, ALARM_BED;
  logic [5:0]        A;
  logic              A_VALID, ALARM;
  logic [2*NBED-1:0] STATE_BUS;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  triage_ward_scheduler #(.NBED(NBED), .SCAN_DIV(D)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .S_BUS     (S_BUS),
    .ACK       (ACK),
    .BED_SEL   (BED_SEL),
    .A         (A),
    .A_VALID   (A_VALID),
    .ALARM     (ALARM),
    .ALARM_BED (ALARM_BED),
    .STATE_BUS (STATE_BUS)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            t;
  logic [1:0]    m_st [NBED];
  logic [5:0]    m_a;
  logic [BW-1:0] m_sel, m_abed;
  logic          m_v, m_alarm, m_ackp;

  function automatic logic [1:0] next_state(input logic [1:0] ps, input logic [5:0] s);
    logic h, n, l1;
    h  = (s[0] && s[1]) || (s[2] && s[3]) || (s[0] && s[2]);
    n  = (s == 6'd0);
    l1 = (s[5] || s[4]) && !h;
    case (ps)
      2'b00:   return h ? 2'b10 : (l1 ? 2'b01 : 2'b00);
      2'b01:   return h ? 2'b10 : (n ? 2'b00 : 2'b01);
      2'b10:   return (h || l1) ? 2'b11 : (n ? 2'b00 : 2'b10);
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [5:0] code_of(input logic [1:0] st);
    case (st)
      2'b01:   return 6'b001100;
      2'b10:   return 6'b011010;
      2'b11:   return 6'b111111;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [2*NBED-1:0] m_stbus();
    logic [2*NBED-1:0] r;
    r = '0;
    for (int i = 0; i < NBED; i++) r[2*i +: 2] = m_st[i];
    return r;
  endfunction

  // Bed services fall at edge D+1+k*D after reset release, bed k mod NBED.
  task automatic model_step();
    logic [1:0] old [NBED];
    logic       clr, a_new;
    int         cb, bed, ab_new;
    logic [1:0] ns;
    if (RST) begin
      t = 0;
      for (int i = 0; i < NBED; i++) m_st[i] = 2'b00;
      m_a = '0; m_sel = '0; m_abed = '0; m_v = 1'b0; m_alarm = 1'b0; m_ackp = 1'b0;
    end else begin
      t++;
      old    = m_st;
      a_new  = 1'b0;
      ab_new = 0;
      for (int i = NBED - 1; i >= 0; i--)
        if (old[i] == 2'b11) begin a_new = 1'b1; ab_new = i; end
      clr = ACK && !m_ackp && m_alarm;
      cb  = int'(m_abed);
      m_v = 1'b0;
      if (t > D && (t - D - 1) % D == 0) begin
        bed = ((t - D - 1) / D) % NBED;
        ns  = next_state(old[bed], S_BUS[6*bed +: 6]);
        if (clr && cb == bed) ns = 2'b00;
        m_st[bed] = ns;
        m_a   = code_of(ns);
        m_sel = BW'(bed);
        m_v   = 1'b1;
      end
      if (clr) m_st[cb] = 2'b00;
      m_alarm = a_new;
      m_abed  = BW'(ab_new);
      m_ackp  = ACK;
    end
  endtask

  always @(posedge CLK) begin
    model_step();
    #1;
    chk("model_outputs", {A_VALID, BED_SEL, A, ALARM, ALARM_BED, STATE_BUS},
        {m_v, m_sel, m_a, m_alarm, m_abed, m_stbus()});
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(posedge CLK); #2; k++;
    end while (!A_VALID && k < 200);
    if (k >= 200) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pulse(input int bed);
    int k;
    k = 0;
    do begin
      @(posedge CLK); #2; k++;
    end while (!(A_VALID && int'(BED_SEL) == bed) && k < 200);
    if (k >= 200) chk("pulse_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cnt, prev_b;
    logic [31:0] r;

    #1 RST = 1'b1;
    #1 chk("reset_async", {A_VALID, BED_SEL, A, ALARM, ALARM_BED, STATE_BUS}, 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;

    wait_valid(cnt);
    chk("first_valid_latency", cnt, D + 1);
    chk("first_bed_sel", BED_SEL, 0);

    S_BUS[11:6] = 6'b010000;
    wait_pulse(1);
    chk("bed1_obs_A", A, 6'b001100);
    chk("bed1_obs_state", STATE_BUS[3:2], 2'b01);
    S_BUS[11:6] = 6'b000000;
    wait_pulse(1);
    chk("bed1_idle_A", A, 6'b000000);
    chk("bed1_idle_state", STATE_BUS[3:2], 2'b00);

    S_BUS[17:12] = 6'b000011;
    wait_pulse(2);
    chk("bed2_pre_A", A, 6'b011010);
    wait_pulse(2);
    chk("bed2_crit_A", A, 6'b111111);
    @(posedge CLK); #2;
    chk("bed2_alarm", {ALARM, ALARM_BED}, {1'b1, 2'd2});
    S_BUS[17:12] = 6'b000000;
    wait_pulse(2);
    chk("bed2_sticky_A", A, 6'b111111);
    chk("bed2_sticky_state", STATE_BUS[5:4], 2'b11);
    ACK = 1'b1;
    @(posedge CLK); #2;
    ACK = 1'b0;
    @(posedge CLK); #2;
    chk("bed2_ack_alarm", ALARM, 1'b0);

    S_BUS[11:6]  = 6'b000011;
    S_BUS[23:18] = 6'b000011;
    wait_pulse(1);
    wait_pulse(1);
    wait_pulse(3);
    S_BUS = '0;
    @(posedge CLK); #2;
    chk("two_crit_alarm", {ALARM, ALARM_BED}, {1'b1, 2'd1});
    ACK = 1'b1;
    @(posedge CLK); #2;
    chk("ack1_bed1_cleared", STATE_BUS[3:2], 2'b00);
    @(posedge CLK); #2;
    chk("ack1_alarm_bed3", {ALARM, ALARM_BED}, {1'b1, 2'd3});
    repeat (20) @(posedge CLK);
    #2 chk("ack_held_bed3", STATE_BUS[7:6], 2'b11);
    ACK = 1'b0;
    @(posedge CLK); #2;
    ACK = 1'b1;
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    chk("ack2_alarm_off", {ALARM, ALARM_BED}, {1'b0, 2'd0});
    ACK = 1'b0;

    S_BUS[5:0] = 6'b000011;
    wait_pulse(0);
    wait_pulse(0);
    S_BUS[5:0] = 6'b111111;
    wait_pulse(3);
    repeat (3) @(posedge CLK);
    #2 ACK = 1'b1;
    @(posedge CLK); #2;
    chk("collide_pulse", {A_VALID, BED_SEL}, {1'b1, 2'd0});
    chk("collide_A", A, 6'b000000);
    chk("collide_state", STATE_BUS[1:0], 2'b00);
    @(posedge CLK); #2;
    chk("collide_alarm_off", ALARM, 1'b0);
    ACK = 1'b0;

    S_BUS = {6'b001000, 6'b000101, 6'b100000, 6'b010000};
    wait_valid(cnt);
    prev_b = int'(BED_SEL);
    for (int p = 0; p < 3 * NBED; p++) begin
      wait_valid(cnt);
      chk("wrap_spacing", cnt, D);
      chk("wrap_bed_sel", BED_SEL, (prev_b + 1) % NBED);
      prev_b = int'(BED_SEL);
    end

    for (int c = 0; c < 800; c++) begin
      @(posedge CLK); #2;
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom;
        S_BUS = r[6*NBED-1:0];
      end
      if ($urandom_range(0, 5) == 0) ACK = ~ACK;
      if (c == 400) begin
        @(negedge CLK); #1 RST = 1'b1;
        #1 chk("reset_midrun", {A_VALID, BED_SEL, A, ALARM, ALARM_BED, STATE_BUS}, 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
      end
    end

    repeat (2) @(posedge CLK);
    #3 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
